// File: rtl/shift_add_mult_8bit_if.sv
// Handshake and operand bus for the 8-bit shift-add multiplier.
// The requester drives start and the operands; the multiplier answers with
// busy, a one-cycle done pulse and the registered product.
interface shift_add_mult_8bit_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/shift_add_mult_8bit.sv
// Sequential 8x8 unsigned multiplier built on a single 8-bit carry-lookahead
// adder. One partial-product bit is retired per RUN cycle by conditionally
// adding the multiplicand into ACC and shifting {C,ACC,Q} right by one.
// A full operation is IDLE -> 8 x RUN -> DONE -> IDLE.

// 8-bit carry-lookahead adder organised as two 4-bit lookahead groups
// with a group-level carry between them.
module cla_adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;
  logic       groupGenLo;
  logic       groupPropLo;
  logic       groupGenHi;
  logic       groupPropHi;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  assign carry[0] = cin_i;

  assign carry[1] = gen[0] | (prop[0] & carry[0]);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & carry[0]);

  assign groupGenLo  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                     | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign groupPropLo = &prop[3:0];

  assign carry[4] = groupGenLo | (groupPropLo & carry[0]);

  assign carry[5] = gen[4] | (prop[4] & carry[4]);
  assign carry[6] = gen[5] | (prop[5] & gen[4]) | (prop[5] & prop[4] & carry[4]);
  assign carry[7] = gen[6] | (prop[6] & gen[5]) | (prop[6] & prop[5] & gen[4])
                  | (prop[6] & prop[5] & prop[4] & carry[4]);

  assign groupGenHi  = gen[7] | (prop[7] & gen[6]) | (prop[7] & prop[6] & gen[5])
                     | (prop[7] & prop[6] & prop[5] & gen[4]);
  assign groupPropHi = &prop[7:4];

  assign carry[8] = groupGenHi | (groupPropHi & groupGenLo)
                  | (groupPropHi & groupPropLo & carry[0]);

  assign sum_o  = prop ^ carry[7:0];
  assign cout_o = carry[8];
endmodule

module shift_add_mult_8bit (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mult_8bit_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  addSum;
  logic        addCout;
  logic [8:0]  partial;

  // The only adder in the block: ACC + M, carry-in grounded.
  cla_adder_8bit adder (
    .a_i    (acc_q),
    .b_i    (m_q),
    .cin_i  (1'b0),
    .sum_o  (addSum),
    .cout_o (addCout)
  );

  // Form {C,ACC} for this step: add M when the current multiplier bit is set.
  // C is always zero between steps because the shift clears it, so carrying
  // it through keeps the 17-bit {C,ACC,Q} view consistent.
  always_comb begin
    partial = {c_q, acc_q};
    if (q_q[0]) begin
      partial = {addCout, addSum};
    end
  end

  // Next-state and datapath update; the shift inserts 0 above C so the MSB
  // entering ACC is always the real carry, never a sign extension.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = 8'h00;
          c_d     = 1'b0;
          cnt_d   = 4'd0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        c_d   = 1'b0;
        acc_d = partial[8:1];
        q_d   = {partial[0], q_q[7:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          prod_d  = {partial[8:1], partial[0], q_q[7:1]};
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // All state, including the registered busy/done flags, with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 8'h00;
      acc_q   <= 8'h00;
      q_q     <= 8'h00;
      c_q     <= 1'b0;
      cnt_q   <= 4'd0;
      prod_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;
endmodule

// File: tb/tb_shift_add_mult_8bit.sv
// Self-checking bench for shift_add_mult_8bit: a vector table of products,
// a scoreboard queue popped on every done pulse, and hand-written sequences
// for mid-run operand changes, reset abort and back-to-back starts.
module tb_shift_add_mult_8bit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_add_mult_8bit_if dutIf ();

  shift_add_mult_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (dutIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expProduct;
  } vector_t;

  vector_t     vectors [12];
  logic [15:0] sbQueue [$];
  int          passCount = 0;
  int          checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request,
  // and busy/done must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy_done_exclusive", 32'(dutIf.busy & dutIf.done), 32'd0);
      if (dutIf.done) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          checkOutput("scoreboard_product", 32'(dutIf.product), 32'(sbQueue.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expProduct);
    @(negedge clk);
    dutIf.a     = a;
    dutIf.b     = b;
    dutIf.start = 1'b1;
    sbQueue.push_back(expProduct);
    @(posedge clk);
    #1;
    dutIf.start = 1'b0;
  endtask

  task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] expProduct, input string name);
    int busyCycles;
    int doneAt;
    busyCycles = 0;
    doneAt     = 0;
    applyStimulus(a, b, expProduct);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dutIf.busy) busyCycles++;
      if (dutIf.done) begin
        doneAt = i;
        break;
      end
    end
    checkOutput({name, "_done_latency"}, 32'(doneAt), 32'd9);
    checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'd8);
    checkOutput({name, "_product"}, 32'(dutIf.product), 32'(expProduct));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneCount;
    int lastStart;
    logic prevBusy;
    logic [15:0] heldProduct;
    logic [7:0]  b2bA [3];
    logic [7:0]  b2bB [3];
    logic [15:0] b2bExp [3];

    vectors[0]  = '{8'h0D, 8'h0B, 16'h008F};
    vectors[1]  = '{8'hFF, 8'hFF, 16'hFE01};
    vectors[2]  = '{8'h00, 8'hA5, 16'h0000};
    vectors[3]  = '{8'h5A, 8'h00, 16'h0000};
    vectors[4]  = '{8'h01, 8'h01, 16'h0001};
    vectors[5]  = '{8'h80, 8'h80, 16'h4000};
    vectors[6]  = '{8'hFF, 8'h01, 16'h00FF};
    vectors[7]  = '{8'h0F, 8'hF0, 16'h0E10};
    vectors[8]  = '{8'hAA, 8'h55, 16'h3872};
    for (int i = 9; i < 12; i++) begin
      vectors[i].a = 8'($urandom_range(0, 255));
      vectors[i].b = 8'($urandom_range(0, 255));
      vectors[i].expProduct = 16'(vectors[i].a) * 16'(vectors[i].b);
    end

    // Reset with start held high: must be ignored.
    dutIf.start = 1'b1;
    dutIf.a     = 8'h55;
    dutIf.b     = 8'h55;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(dutIf.busy), 32'd0);
    checkOutput("reset_done", 32'(dutIf.done), 32'd0);
    checkOutput("reset_product", 32'(dutIf.product), 32'd0);
    rst = 1'b0;
    dutIf.start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_after_reset_busy", 32'(dutIf.busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      runOp(vectors[i].a, vectors[i].b, vectors[i].expProduct, $sformatf("vec%0d", i));
    end

    // Start and new operands during RUN must be ignored.
    applyStimulus(8'h07, 8'h06, 16'h002A);
    doneCount = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) begin
        dutIf.a     = 8'h02;
        dutIf.b     = 8'h03;
        dutIf.start = 1'b1;
      end
      if (i == 7) dutIf.start = 1'b0;
      if (dutIf.done) doneCount++;
    end
    checkOutput("ignore_start_done_count", 32'(doneCount), 32'd1);
    checkOutput("ignore_start_product", 32'(dutIf.product), 32'h002A);

    // Reset in the middle of RUN aborts without a done pulse.
    applyStimulus(8'hFF, 8'h02, 16'h01FE);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    dutIf.start = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(dutIf.busy), 32'd0);
    checkOutput("abort_done", 32'(dutIf.done), 32'd0);
    checkOutput("abort_product", 32'(dutIf.product), 32'd0);
    repeat (2) @(negedge clk);
    sbQueue.delete();
    rst = 1'b0;
    dutIf.start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dutIf.done) doneCount++;
    end
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    runOp(8'h03, 8'h04, 16'h000C, "after_abort");

    // Back-to-back with start held high.
    b2bA[0] = 8'h11; b2bB[0] = 8'h22;
    b2bA[1] = 8'h33; b2bB[1] = 8'h44;
    b2bA[2] = 8'hFF; b2bB[2] = 8'hFE;
    for (int k = 0; k < 3; k++) b2bExp[k] = 16'(b2bA[k]) * 16'(b2bB[k]);
    heldProduct = 16'h000C;
    @(negedge clk);
    dutIf.a     = b2bA[0];
    dutIf.b     = b2bB[0];
    dutIf.start = 1'b1;
    sbQueue.push_back(b2bExp[0]);
    doneCount = 0;
    lastStart = -1;
    prevBusy  = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (dutIf.busy && !prevBusy) begin
        if (lastStart >= 0) checkOutput("b2b_start_spacing", 32'(i - lastStart), 32'd10);
        lastStart = i;
      end
      prevBusy = dutIf.busy;
      if (dutIf.done && doneCount < 3) begin
        heldProduct = b2bExp[doneCount];
        doneCount++;
        if (doneCount < 3) begin
          dutIf.a = b2bA[doneCount];
          dutIf.b = b2bB[doneCount];
          sbQueue.push_back(b2bExp[doneCount]);
        end else begin
          dutIf.start = 1'b0;
        end
      end
      checkOutput("b2b_product_hold", 32'(dutIf.product), 32'(heldProduct));
    end
    dutIf.start = 1'b0;
    checkOutput("b2b_done_count", 32'(doneCount), 32'd3);
    checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
